// File: rtl/soc_csr_arb.sv
// soc_csr_arb: two-master round-robin arbiter in front of a single CSR slave port.
// One transaction is in flight at a time: IDLE picks a winner, BUSY presents
// the request to the slave until it accepts, and RESP returns a one-cycle
// m_rdy strobe to the granted master.
// Optional build macro CSR_ARB_TIMEOUT_EN: compiles in a slave-wait watchdog.
// The watchdog aborts a stalled slave cycle after TIMEOUT_CYC BUSY cycles and
// answers the master with 32'hDEAD_BEEF plus a to_err strobe. Without the
// macro, BUSY waits for s_rdy forever and to_err is tied low.
module soc_csr_arb #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             m_vld,
  input  logic [1:0][3:0]        m_we,
  input  logic [1:0][ADDR_W-1:0] m_addr,
  input  logic [1:0][31:0]       m_wdat,
  output logic [1:0]             m_rdy,
  output logic [31:0]            m_rdat,
  output logic                   s_vld,
  output logic [3:0]             s_we,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [31:0]            s_wdat,
  input  logic                   s_rdy,
  input  logic [31:0]            s_rdat,
  output logic                   gnt_id,
  output logic                   busy,
  output logic                   to_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_r;
  logic   last_gnt_r;  // master served by the most recent completed transaction
  logic   win_s;       // master that would be granted this cycle

`ifdef CSR_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt_r;
`endif

  // Round-robin pick: on contention the master not served last wins
  always_comb begin
    win_s = 1'b0;
    if (m_vld == 2'b11) begin
      win_s = ~last_gnt_r;
    end else if (m_vld[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Transaction FSM; every output is a flop so the slave and masters see clean timing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      s_vld      <= 1'b0;
      s_we       <= 4'b0000;
      s_addr     <= {ADDR_W{1'b0}};
      s_wdat     <= 32'h0000_0000;
      m_rdy      <= 2'b00;
      m_rdat     <= 32'h0000_0000;
      gnt_id     <= 1'b0;
      busy       <= 1'b0;
      last_gnt_r <= 1'b1;  // pretend master 1 went last so master 0 wins first
`ifdef CSR_ARB_TIMEOUT_EN
      to_err     <= 1'b0;
      cnt_r      <= 16'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (m_vld != 2'b00) begin
            // Latch the winner's request; the loser is ignored until the next IDLE
            gnt_id  <= win_s;
            s_vld   <= 1'b1;
            s_we    <= m_we[win_s];
            s_addr  <= m_addr[win_s];
            s_wdat  <= m_wdat[win_s];
            busy    <= 1'b1;
            state_r <= ST_BUSY;
`ifdef CSR_ARB_TIMEOUT_EN
            cnt_r   <= 16'd0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (s_rdy) begin
            // Slave accepted: capture read data (also on writes) and answer the master
            m_rdat     <= s_rdat;
            m_rdy      <= gnt_id ? 2'b10 : 2'b01;
            last_gnt_r <= gnt_id;
            s_vld      <= 1'b0;
            s_we       <= 4'b0000;
            state_r    <= ST_RESP;
          end
`ifdef CSR_ARB_TIMEOUT_EN
          else if (cnt_r == TO_LAST) begin
            // Slave never answered: abort and hand back a recognisable poison value
            m_rdat     <= 32'hDEAD_BEEF;
            m_rdy      <= gnt_id ? 2'b10 : 2'b01;
            to_err     <= 1'b1;
            last_gnt_r <= gnt_id;
            s_vld      <= 1'b0;
            s_we       <= 4'b0000;
            state_r    <= ST_RESP;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
            state_r <= ST_BUSY;
          end
`else
          else begin
            state_r <= ST_BUSY;
          end
`endif
        end
        ST_RESP: begin
          m_rdy   <= 2'b00;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
`ifdef CSR_ARB_TIMEOUT_EN
          to_err  <= 1'b0;
`endif
        end
        default: begin
          // Unreachable encoding: fall back to a quiet IDLE
          state_r <= ST_IDLE;
          s_vld   <= 1'b0;
          s_we    <= 4'b0000;
          m_rdy   <= 2'b00;
          busy    <= 1'b0;
`ifdef CSR_ARB_TIMEOUT_EN
          to_err  <= 1'b0;
`endif
        end
      endcase
    end
  end

`ifndef CSR_ARB_TIMEOUT_EN
  assign to_err = 1'b0;
`endif

endmodule

// File: tb/tb_soc_csr_arb.sv
// Directed testbench for soc_csr_arb. Inputs are driven 1 ns after each rising
// edge and outputs are checked at the same point, when the flops are settled.
// The timeout scenario is compiled only when CSR_ARB_TIMEOUT_EN is defined.
// Otherwise the bench checks that a long stall is never aborted.
module tb_soc_csr_arb;

  logic             clk;
  logic             rst;
  logic [1:0]       m_vld;
  logic [1:0][3:0]  m_we;
  logic [1:0][31:0] m_addr;
  logic [1:0][31:0] m_wdat;
  logic [1:0]       m_rdy;
  logic [31:0]      m_rdat;
  logic             s_vld;
  logic [3:0]       s_we;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdat;
  logic             s_rdy;
  logic [31:0]      s_rdat;
  logic             gnt_id;
  logic             busy;
  logic             to_err;

  int n_checks;
  int n_fail;

  soc_csr_arb #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .m_vld  (m_vld),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdat (m_wdat),
    .m_rdy  (m_rdy),
    .m_rdat (m_rdat),
    .s_vld  (s_vld),
    .s_we   (s_we),
    .s_addr (s_addr),
    .s_wdat (s_wdat),
    .s_rdy  (s_rdy),
    .s_rdat (s_rdat),
    .gnt_id (gnt_id),
    .busy   (busy),
    .to_err (to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst    = 1'b1;
    m_vld  = 2'b00;
    m_we   = '0;
    m_addr = '0;
    m_wdat = '0;
    s_rdy  = 1'b0;
    s_rdat = 32'h0000_0000;
    tick();
    tick();

    // Reset state
    chk("rst_s_vld",  {31'd0, s_vld},  32'd0);
    chk("rst_s_we",   {28'd0, s_we},   32'd0);
    chk("rst_m_rdy",  {30'd0, m_rdy},  32'd0);
    chk("rst_m_rdat", m_rdat,          32'd0);
    chk("rst_gnt",    {31'd0, gnt_id}, 32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_to_err", {31'd0, to_err}, 32'd0);
    rst = 1'b0;

    // Single read from master 0
    m_vld     = 2'b01;
    m_addr[0] = 32'h0000_0010;
    s_rdy     = 1'b1;
    s_rdat    = 32'h1234_5678;
    tick();
    chk("rd_s_vld",  {31'd0, s_vld},  32'd1);
    chk("rd_s_addr", s_addr,          32'h0000_0010);
    chk("rd_s_we",   {28'd0, s_we},   32'd0);
    chk("rd_gnt",    {31'd0, gnt_id}, 32'd0);
    chk("rd_busy",   {31'd0, busy},   32'd1);
    chk("rd_m_rdy0", {30'd0, m_rdy},  32'd0);
    tick();
    chk("rd_m_rdy",  {30'd0, m_rdy},  32'd1);
    chk("rd_m_rdat", m_rdat,          32'h1234_5678);
    chk("rd_s_vld2", {31'd0, s_vld},  32'd0);
    m_vld = 2'b00;
    tick();
    chk("rd_idle_rdy",  {30'd0, m_rdy}, 32'd0);
    chk("rd_idle_busy", {31'd0, busy},  32'd0);

    // Contention from reset: grants alternate 0,1,0,1 every 3 cycles
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    m_vld     = 2'b11;
    m_addr[0] = 32'h0000_0100;
    m_addr[1] = 32'h0000_0200;
    s_rdy     = 1'b1;
    for (int g = 0; g < 4; g++) begin
      s_rdat = 32'hC0DE_0000 + 32'(g);
      tick();
      chk("cont_gnt",   {31'd0, gnt_id}, 32'(g % 2));
      chk("cont_addr",  s_addr, (g % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
      chk("cont_s_vld", {31'd0, s_vld}, 32'd1);
      tick();
      chk("cont_m_rdy", {30'd0, m_rdy}, (g % 2 == 1) ? 32'd2 : 32'd1);
      chk("cont_m_rdat", m_rdat, 32'hC0DE_0000 + 32'(g));
      tick();
      chk("cont_rdy_off", {30'd0, m_rdy}, 32'd0);
    end

    // Write stall on master 1: request held stable through 5 stall cycles
    m_vld     = 2'b10;
    m_we[1]   = 4'b0011;
    m_wdat[1] = 32'hAABB_CCDD;
    m_addr[1] = 32'h0000_0044;
    s_rdy     = 1'b0;
    s_rdat    = 32'h0BAD_F00D;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("wr_s_vld",  {31'd0, s_vld}, 32'd1);
      chk("wr_s_we",   {28'd0, s_we},  32'd3);
      chk("wr_s_wdat", s_wdat,         32'hAABB_CCDD);
      chk("wr_m_rdy",  {30'd0, m_rdy}, 32'd0);
      if (i == 5) s_rdy = 1'b1;
      tick();
    end
    chk("wr_done_rdy",  {30'd0, m_rdy}, 32'd2);
    chk("wr_done_svld", {31'd0, s_vld}, 32'd0);
    chk("wr_done_swe",  {28'd0, s_we},  32'd0);
    chk("wr_done_rdat", m_rdat,         32'h0BAD_F00D);
    m_vld   = 2'b00;
    m_we[1] = 4'b0000;
    tick();

    // Reset during BUSY: master 0 served last, master 1 stalls, then reset
    m_vld = 2'b01;
    s_rdy = 1'b1;
    tick();
    tick();
    chk("pre_m_rdy", {30'd0, m_rdy}, 32'd1);
    m_vld = 2'b00;
    tick();
    m_vld = 2'b10;
    s_rdy = 1'b0;
    tick();
    chk("rb_gnt",   {31'd0, gnt_id}, 32'd1);
    chk("rb_s_vld", {31'd0, s_vld},  32'd1);
    rst = 1'b1;
    tick();
    chk("rb_after_svld", {31'd0, s_vld}, 32'd0);
    chk("rb_after_busy", {31'd0, busy},  32'd0);
    chk("rb_after_rdy",  {30'd0, m_rdy}, 32'd0);
    rst   = 1'b0;
    m_vld = 2'b11;
    s_rdy = 1'b1;
    tick();
    chk("rb_next_gnt", {31'd0, gnt_id}, 32'd0);
    chk("rb_next_rdy", {30'd0, m_rdy},  32'd0);
    tick();
    chk("rb_next_m_rdy", {30'd0, m_rdy}, 32'd1);
    m_vld = 2'b00;
    tick();

`ifdef CSR_ARB_TIMEOUT_EN
    // Watchdog: 8 BUSY cycles without s_rdy, then poison response
    m_vld = 2'b01;
    s_rdy = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("to_s_vld", {31'd0, s_vld}, 32'd1);
      chk("to_err_lo", {31'd0, to_err}, 32'd0);
      tick();
    end
    chk("to_drop_svld", {31'd0, s_vld},  32'd0);
    chk("to_m_rdy",     {30'd0, m_rdy},  32'd1);
    chk("to_m_rdat",    m_rdat,          32'hDEAD_BEEF);
    chk("to_err_hi",    {31'd0, to_err}, 32'd1);
    tick();
    chk("to_err_clr", {31'd0, to_err}, 32'd0);
    chk("to_rdy_clr", {30'd0, m_rdy},  32'd0);
    s_rdy  = 1'b1;
    s_rdat = 32'h5555_AAAA;
    tick();
    tick();
    chk("to_next_rdy",  {30'd0, m_rdy}, 32'd1);
    chk("to_next_rdat", m_rdat,         32'h5555_AAAA);
    chk("to_next_err",  {31'd0, to_err}, 32'd0);
    m_vld = 2'b00;
    tick();
`else
    // No watchdog: a long stall is never aborted and to_err stays low
    m_vld = 2'b01;
    s_rdy = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) tick();
    chk("nto_s_vld", {31'd0, s_vld},  32'd1);
    chk("nto_m_rdy", {30'd0, m_rdy},  32'd0);
    chk("nto_err",   {31'd0, to_err}, 32'd0);
    s_rdy  = 1'b1;
    s_rdat = 32'h5555_AAAA;
    tick();
    chk("nto_done_rdy",  {30'd0, m_rdy}, 32'd1);
    chk("nto_done_rdat", m_rdat,         32'h5555_AAAA);
    m_vld = 2'b00;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
